// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcodes, latencies, FSM states.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NOP = 4'd0,
        MULT   = 4'd1,
        MULTU  = 4'd2,
        DIV    = 4'd3,
        DIVU   = 4'd4,
        MTHI   = 4'd5,
        MTLO   = 4'd6,
        MADD   = 4'd7,
        MADDU  = 4'd8,
        MSUB   = 4'd9,
        MSUBU  = 4'd10
    } md_op_t;

    localparam logic [3:0] MUL_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_if.sv
// Operand/opcode and HI/LO result bundle between the ID/EX register, the MDU and its readers.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    logic        cancel;
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, cancel, op, a, b, input busy, hi, lo);
    modport slave  (input start, cancel, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit {hi,lo} result generation for every MD opcode.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) exist only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        run,
    output logic [3:0]  lat,
    output logic        set_hi,
    output logic        set_lo
);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
    logic        [31:0] quo_u, rem_u;
    logic               unused_div_msb;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // 33-bit signed divide so that -2^31 / -1 wraps to 0x80000000 instead of overflowing
    assign dvd_s = $signed({a[31], a});
    assign dvs_s = $signed({b[31], b});
    assign quo_s = dvd_s / dvs_s;
    assign rem_s = dvd_s % dvs_s;
    assign quo_u = a / b;
    assign rem_u = a % b;
    assign unused_div_msb = quo_s[32] ^ rem_s[32];

    always_comb begin
        res    = {hi, lo};
        run    = 1'b0;
        lat    = 4'd0;
        set_hi = 1'b0;
        set_lo = 1'b0;
        case (op)
            MULT:  begin run = 1'b1; lat = MUL_LAT; res = prod_s; end
            MULTU: begin run = 1'b1; lat = MUL_LAT; res = prod_u; end
            DIV: begin
                run = 1'b1;
                lat = DIV_LAT;
                if (b != 32'd0) res = {rem_s[31:0], quo_s[31:0]};
            end
            DIVU: begin
                run = 1'b1;
                lat = DIV_LAT;
                if (b != 32'd0) res = {rem_u, quo_u};
            end
            MTHI: set_hi = 1'b1;
            MTLO: set_lo = 1'b1;
`ifdef MDU_MADD_EN
            MADD:  begin run = 1'b1; lat = MUL_LAT; res = {hi, lo} + prod_s; end
            MADDU: begin run = 1'b1; lat = MUL_LAT; res = {hi, lo} + prod_u; end
            MSUB:  begin run = 1'b1; lat = MUL_LAT; res = {hi, lo} - prod_s; end
            MSUBU: begin run = 1'b1; lat = MUL_LAT; res = {hi, lo} - prod_u; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: accept FSM, latency counter and HI/LO registers.
// MDU_MADD_EN enables the accumulate opcodes in mdu_calc.
module mdu_ex
    import mdu_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    mdu_if.slave md
);
    mdu_state_t  state, next_state;
    logic [3:0]  cnt;
    logic [63:0] res_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] calc_res;
    logic [3:0]  calc_lat;
    logic        calc_run, set_hi, set_lo, accept;

    mdu_calc u_calc (
        .op     (md.op),
        .a      (md.a),
        .b      (md.b),
        .hi     (hi_q),
        .lo     (lo_q),
        .res    (calc_res),
        .run    (calc_run),
        .lat    (calc_lat),
        .set_hi (set_hi),
        .set_lo (set_lo)
    );

    assign accept = md.start & ~md.cancel & (state == IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && calc_run) next_state = RUN;
            RUN:     if (cnt == 4'd1) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result is frozen at accept; HI/LO only move on MTHI/MTLO or the final RUN edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            res_q <= 64'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (accept && calc_run) begin
                    cnt   <= calc_lat;
                    res_q <= calc_res;
                end
                if (accept && set_hi) hi_q <= md.a;
                if (accept && set_lo) lo_q <= md.a;
            end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    hi_q <= res_q[63:32];
                    lo_q <= res_q[31:0];
                end
            end
        end
    end

    assign md.busy = (state == RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ex.sv
// Randomized self-checking bench for mdu_ex against an arithmetic HI/LO reference model.
// Accumulate scenarios follow MDU_MADD_EN.
module tb_mdu_ex;
    import mdu_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [63:0] model_acc;

    mdu_if bus ();

    mdu_ex dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what {HI,LO} becomes and how many busy cycles an accepted op costs
    function automatic void model_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [63:0] acc, output logic [63:0] nxt, output int lat);
        longint sa, sb;
        logic [63:0] ps, pu;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = 64'(sa * sb);
        pu  = {32'd0, a} * {32'd0, b};
        nxt = acc;
        lat = 0;
        case (op)
            MULT:  begin nxt = ps; lat = 5; end
            MULTU: begin nxt = pu; lat = 5; end
            DIV: begin
                lat = 10;
                if (b != 0) nxt = {32'(sa % sb), 32'(sa / sb)};
            end
            DIVU: begin
                lat = 10;
                if (b != 0) nxt = {a % b, a / b};
            end
            MTHI: nxt[63:32] = a;
            MTLO: nxt[31:0]  = a;
`ifdef MDU_MADD_EN
            MADD:  begin nxt = acc + ps; lat = 5; end
            MADDU: begin nxt = acc + pu; lat = 5; end
            MSUB:  begin nxt = acc - ps; lat = 5; end
            MSUBU: begin nxt = acc - pu; lat = 5; end
`endif
            default: ;
        endcase
    endfunction

    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic cn, input string name);
        logic [63:0] exp_acc;
        int exp_lat;
        int n;
        if (cn) begin
            exp_acc = model_acc;
            exp_lat = 0;
        end else begin
            model_op(op, a, b, model_acc, exp_acc, exp_lat);
        end
        @(negedge clk);
        bus.start  = 1'b1;
        bus.cancel = cn;
        bus.op     = op;
        bus.a      = a;
        bus.b      = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("[TB] FAIL %s busy_cycles got %0d exp %0d", name, n, exp_lat);
        end
        checks++;
        if ({bus.hi, bus.lo} !== exp_acc) begin
            errors++;
            $display("[TB] FAIL %s hilo got %h_%h exp %h", name, bus.hi, bus.lo, exp_acc);
        end
        model_acc = exp_acc;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = MD_NOP;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        model_acc  = 64'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got busy=%b hi=%h lo=%h exp 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_mult();
        run_op(MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_neg1x2");
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL mult_const got %h_%h exp ffffffff_fffffffe", bus.hi, bus.lo);
        end
        run_op(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_maxx2");
        checks++;
        if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL multu_const got %h_%h exp 00000001_fffffffe", bus.hi, bus.lo);
        end
        for (int i = 0; i < 4; i++) begin
            run_op((i % 2 == 0) ? MULT : MULTU, $urandom, $urandom, 1'b0, "mult_rand");
        end
    endtask

    task automatic test_div();
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7by2");
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("[TB] FAIL div_const got %h_%h exp ffffffff_fffffffd", bus.hi, bus.lo);
        end
        run_op(DIVU, 32'd7, 32'd0, 1'b0, "divu_by_zero");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        for (int i = 0; i < 4; i++) begin
            run_op((i % 2 == 0) ? DIV : DIVU, $urandom, $urandom_range(1, 5000), 1'b0, "div_rand");
        end
    endtask

    task automatic test_cancel_and_move();
        run_op(MULT, 32'd3, 32'd3, 1'b1, "mult_cancelled");
        run_op(MTHI, 32'h0000_1234, 32'd0, 1'b0, "mthi");
        checks++;
        if (bus.hi !== 32'h0000_1234) begin
            errors++;
            $display("[TB] FAIL mthi_const got %h exp 00001234", bus.hi);
        end
        run_op(MTLO, $urandom, 32'd0, 1'b0, "mtlo_rand");
    endtask

    task automatic test_back_to_back();
        logic [63:0] div_acc, mul_acc;
        logic [31:0] ma, mb;
        int lat_d, lat_m, n;
        ma = $urandom;
        mb = $urandom;
        model_op(DIV, 32'd1000, 32'hFFFF_FFFD, model_acc, div_acc, lat_d);
        model_op(MULT, ma, mb, div_acc, mul_acc, lat_m);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = DIV;
        bus.a     = 32'd1000;
        bus.b     = 32'hFFFF_FFFD;
        @(negedge clk);
        bus.op = MULT;
        bus.a  = ma;
        bus.b  = mb;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== lat_d || {bus.hi, bus.lo} !== div_acc) begin
            errors++;
            $display("[TB] FAIL busy_ignore got cycles=%0d hilo=%h_%h exp %0d %h", n, bus.hi, bus.lo, lat_d, div_acc);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== lat_m || {bus.hi, bus.lo} !== mul_acc) begin
            errors++;
            $display("[TB] FAIL back_to_back got cycles=%0d hilo=%h_%h exp %0d %h", n, bus.hi, bus.lo, lat_m, mul_acc);
        end
        model_acc = mul_acc;
    endtask

    task automatic test_reset_mid_run();
        run_op(MTLO, 32'hA5A5_0001, 32'd0, 1'b0, "mtlo_pre");
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = DIV;
        bus.a     = 32'd99;
        bus.b     = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run got busy=%b hi=%h lo=%h exp 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        model_acc = 64'd0;
        @(negedge clk);
        reset_n = 1'b1;
        run_op(MULT, 32'd12345, 32'hFFFF_FF00, 1'b0, "mult_after_reset");
    endtask

    task automatic test_madd();
        run_op(MTHI, 32'd0, 32'd0, 1'b0, "madd_init_hi");
        run_op(MTLO, 32'd5, 32'd0, 1'b0, "madd_init_lo");
`ifdef MDU_MADD_EN
        run_op(MADD, 32'd3, 32'd4, 1'b0, "madd");
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd17) begin
            errors++;
            $display("[TB] FAIL madd_const got %h_%h exp 00000000_00000011", bus.hi, bus.lo);
        end
        run_op(MSUBU, 32'd1, 32'd18, 1'b0, "msubu");
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL msubu_const got %h_%h exp ffffffff_ffffffff", bus.hi, bus.lo);
        end
        run_op(MADDU, $urandom, $urandom, 1'b0, "maddu_rand");
        run_op(MSUB, $urandom, $urandom, 1'b0, "msub_rand");
`else
        run_op(MADD, 32'd3, 32'd4, 1'b0, "op7_nop");
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd5) begin
            errors++;
            $display("[TB] FAIL op7_const got %h_%h exp 00000000_00000005", bus.hi, bus.lo);
        end
`endif
    endtask

    task automatic test_random();
        md_op_t op;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            op = md_op_t'(4'($urandom_range(0, 15)));
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(op, $urandom, b, ($urandom_range(0, 7) == 0), "random_op");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_div();
        test_cancel_and_move();
        test_back_to_back();
        test_reset_mid_run();
        test_madd();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ex.md
# mdu_ex

Multiply/divide unit for the EX stage of the pipelined MIPS core. It consumes the operands and MD opcode latched by the ID/EX pipeline register. It runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and owns the HI/LO registers. It raises `busy` so the hazard unit can stall MD-dependent instructions through the pipeline registers' stall inputs.

## Interface
- No parameters; latencies are package constants.
- `clk` in 1: core clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: EX-stage instruction is an MD op; sampled on the rising edge.
- `cancel` in 1: exception/interrupt flush of the EX instruction; suppresses `start` in the same cycle.
- `op` in 4: MD opcode, encoding in the shared package.
- `a` in 32: rs operand.
- `b` in 32: rt operand.
- `busy` out 1: multi-cycle operation in flight.
- `hi` out 32: HI register, read by MFHI.
- `lo` out 32: LO register, read by MFLO.

## Operation
- Accept = `start & ~cancel & ~busy`. If `busy` is high, `start` is ignored; the upstream stall guarantees this never happens legally.
- FSM states:
  - IDLE → RUN on an accepted MULT/MULTU/DIV/DIVU (and MADD* ops when enabled).
  - RUN → IDLE when the counter reaches 1.
  - `busy` = (state == RUN).
- On accept:
  - Counter loads MUL_LAT = 5 or DIV_LAT = 10.
  - Result pair {res_hi, res_lo} is computed from `a`/`b` and latched in an internal register.
  - HI/LO are untouched until completion.
- MULT: 64-bit signed product; MULTU: unsigned. HI = bits 63:32, LO = bits 31:0.
- DIV/DIVU:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend for DIV.
- Divide by zero: still 10 busy cycles; HI/LO unchanged at completion.
- MTHI/MTLO:
  - Write `a` into HI or LO at the accepting edge.
  - No RUN state, `busy` stays 0.
- MD_NOP or an unknown op: no effect.
- `cancel` does not abort an operation already in RUN.
- Reset (any time, including mid-RUN): state = IDLE, counter = 0, `busy` = 0, `hi` = 0, `lo` = 0, internal result = 0, effective immediately.

## Timing
- Accept at edge E0.
- `busy` is high for cycles E0+1 … E0+LAT (5 or 10 cycles).
- HI/LO are written at the edge ending the last busy cycle. The new value is visible in the same cycle `busy` falls.
- MTHI/MTLO: value visible in the cycle after the accepting edge.
- Back-to-back: a new op can be accepted in the first cycle with `busy` = 0.

## Configuration
- `MDU_MADD_EN` defined:
  - MADD/MADDU: {HI,LO} += a×b (signed/unsigned).
  - MSUB/MSUBU: {HI,LO} −= a×b.
  - All use the 64-bit wrap-around, MUL_LAT latency and the current HI/LO captured at accept.
- Undefined: opcodes 7–10 decode as MD_NOP and no accumulator logic is built.

## Structure
- Shared package `mdu_pkg`:
  - `md_op_t` 4-bit encoding: MD_NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - Constants MUL_LAT=5, DIV_LAT=10.
  - State enum `mdu_state_t` {IDLE, RUN}.
- One natural sub-module, `mdu_calc`: combinational 64-bit result generation for all ops. The FSM, counter and HI/LO registers stay in `mdu_ex`.

## Test plan
- MULT, a=0xFFFFFFFF, b=2 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV, a=0xFFFFFFF9 (−7), b=2 → `busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, a=7, b=0 → 10 busy cycles, HI/LO unchanged.
- `start`=1 with `cancel`=1 on MULT → `busy` stays 0, HI/LO unchanged. MTHI a=0x1234 → HI=0x00001234 the next cycle, `busy`=0.
- During RUN of a DIV, present MULT with `start`=1 → ignored, DIV result only. Then MULT in the first non-busy cycle → accepted.
- `reset_n` low at cycle 4 of a DIV → `busy`=0, HI=LO=0 asynchronously. After release, a fresh MULT completes normally.
- With `MDU_MADD_EN`: HI:LO=0:5, MADD a=3, b=4 → LO=17, HI=0. MSUBU a=1, b=18 → HI=0xFFFFFFFF, LO=0xFFFFFFFF. Without the macro, op=7 → no change, `busy`=0.
